pipeline_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core. It drives the per-stage register enables and flushes. It inserts the load-use bubble that operand forwarding cannot cover, flushes the front end on a branch mispredict resolved in EX, and freezes the whole pipe while data memory is not ready. It also keeps saturating hazard counters and a sticky memory-timeout flag for debug.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/pipeline_ctrl_if.sv | 29 ++
 rtl/pipeline_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline control logic. The forwarding unit imports this package too.
package pipeline_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MEMWAIT  = 2'd2
    } state_t;

    // Opcodes whose rs1 field names a real source register.
    function automatic logic reads_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    // Opcodes whose rs2 field names a real source register.
    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side signals seen by the sequencing controller: hazard inputs and stage controls.
interface pipeline_ctrl_if;

    logic [31:0] inst_id;
    logic [31:0] inst_ex;
    logic        mispredict_ex;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;

    // Core datapath side: presents instructions and memory status, obeys enables.
    modport master (
        output inst_id, inst_ex, mispredict_ex, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush
    );

    // Controller side.
    modport slave (
        input  inst_id, inst_ex, mispredict_ex, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush
    );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID; forwarding cannot cover it.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic [31:0] inst_id,
    input  logic [31:0] inst_ex,
    output logic        lu
);

    logic [4:0] ld_rd;
    logic       ex_is_load;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_bits;

    assign ld_rd      = inst_ex[11:7];
    assign ex_is_load = (inst_ex[6:0] == OP_LOAD) && (ld_rd != 5'd0);
    assign rs1_hit    = reads_rs1(inst_id[6:0]) && (inst_id[19:15] == ld_rd);
    assign rs2_hit    = reads_rs2(inst_id[6:0]) && (inst_id[24:20] == ld_rd);
    assign lu         = ex_is_load && (rs1_hit || rs2_hit);

    // Immediate/funct fields play no part in hazard detection.
    assign unused_bits = ^{inst_ex[31:12], inst_id[31:25], inst_id[14:7]};

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, redirect window, memory freeze, debug counters.
//
// state    | meaning
// RUN      | normal flow; mispredict and load-use are acted on
// REDIRECT | IF/ID held flushed while the fetch redirect settles (rcnt cycles left)
// MEMWAIT  | pipe frozen on data memory; ret remembers where to resume
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int REDIRECT_LAT = 2,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipeline_ctrl_if.slave     bus,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [CNT_W-1:0]   wait_cnt,
    output logic               mem_timeout
);

    localparam int RCNT_W = (REDIRECT_LAT > 1) ? $clog2(REDIRECT_LAT) : 1;
    localparam int RUN_W  = $clog2(MEM_TIMEOUT + 1);

    state_t             state, state_n, ret, ret_n, eff;
    logic [RCNT_W-1:0]  rcnt, rcnt_n;
    logic [RUN_W-1:0]   run_cnt;
    logic               freeze, lu, mp;
    logic               stall_cyc, flush_cyc;
    logic [6:0]         ctl;

    load_use_detect u_lu (
        .inst_id (bus.inst_id),
        .inst_ex (bus.inst_ex),
        .lu      (lu)
    );

    assign mp     = bus.mispredict_ex;
    assign freeze = bus.dmem_req & ~bus.dmem_ready;
    // Once memory releases, the frozen cycle resumes the interrupted state's behaviour.
    assign eff    = (state == MEMWAIT && !freeze) ? ret : state;

    // Mealy stage controls, packed as {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}.
    always_comb begin
        ctl       = 7'b11111_00;
        stall_cyc = 1'b0;
        flush_cyc = 1'b0;
        if (freeze) begin
            ctl = 7'b00000_00;
        end else if (eff == RUN && mp) begin
            ctl       = 7'b11111_11;
            flush_cyc = 1'b1;
        end else if (eff == RUN && lu) begin
            ctl       = 7'b00111_01;
            stall_cyc = 1'b1;
        end else if (eff == REDIRECT) begin
            ctl = 7'b11111_10;
        end
        if (rst) begin
            ctl = 7'b00000_00;
        end
    end

    assign {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush} = ctl;

    // Next state, return state and redirect countdown.
    always_comb begin
        state_n = state;
        ret_n   = ret;
        rcnt_n  = rcnt;
        if (freeze) begin
            state_n = MEMWAIT;
            if (state != MEMWAIT) begin
                ret_n = state;
            end
        end else if (eff == RUN) begin
            state_n = RUN;
            if (mp && REDIRECT_LAT > 1) begin
                state_n = REDIRECT;
                rcnt_n  = RCNT_W'(REDIRECT_LAT - 1);
            end
        end else if (eff == REDIRECT) begin
            state_n = REDIRECT;
            if (mp) begin
                rcnt_n = RCNT_W'(REDIRECT_LAT - 1);
            end else if (rcnt == RCNT_W'(1)) begin
                state_n = RUN;
            end else begin
                rcnt_n = rcnt - RCNT_W'(1);
            end
        end else begin
            state_n = eff;
        end
    end

    // FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            ret   <= RUN;
            rcnt  <= '0;
        end else begin
            state <= state_n;
            ret   <= ret_n;
            rcnt  <= rcnt_n;
        end
    end

    // Saturating hazard counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (stall_cyc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_cyc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            if (freeze && wait_cnt != '1)     wait_cnt  <= wait_cnt + CNT_W'(1);
        end
    end

    // Consecutive-freeze run length and the sticky timeout flag it drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (!freeze) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_W'(MEM_TIMEOUT)) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
            if (freeze && run_cnt >= RUN_W'(MEM_TIMEOUT - 1)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed cases then random traffic against a cycle model.
module tb_pipeline_ctrl;

    localparam int LAT   = 2;
    localparam int MT    = 4;
    localparam int CW    = 6;
    localparam int MAXC  = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [CW-1:0]  stall_cnt, flush_cnt, wait_cnt;
    logic           mem_timeout;

    int errors = 0;
    int checks = 0;

    int m_stall, m_flush, m_wait, m_run, m_redir;
    bit m_to;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.REDIRECT_LAT(LAT), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .wait_cnt    (wait_cnt),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl_obs();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // Load-use rule evaluated straight from the instruction fields.
    function automatic bit model_lu(input logic [31:0] id, input logic [31:0] ex);
        int  rd, rs1, rs2, op;
        bit  use1, use2;
        rd  = int'(ex[11:7]);
        rs1 = int'(id[19:15]);
        rs2 = int'(id[24:20]);
        op  = int'(id[6:0]);
        if (ex[6:0] != 7'h03 || rd == 0) return 0;
        use1 = (op == 'h33) || (op == 'h13) || (op == 'h03) || (op == 'h23) || (op == 'h63) || (op == 'h67);
        use2 = (op == 'h33) || (op == 'h23) || (op == 'h63);
        return (use1 && rs1 == rd) || (use2 && rs2 == rd);
    endfunction

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_wait = 0; m_run = 0; m_redir = 0; m_to = 0;
    endtask

    // One clock cycle: drive at negedge, check controls, advance model, check registers after the edge.
    task automatic step(input logic [31:0] id, input logic [31:0] ex,
                        input logic mp, input logic req, input logic rdy);
        bit         fz, lu;
        logic [6:0] exp_ctl;
        bus.inst_id       = id;
        bus.inst_ex       = ex;
        bus.mispredict_ex = mp;
        bus.dmem_req      = req;
        bus.dmem_ready    = rdy;
        #1;
        fz = req & ~rdy;
        lu = model_lu(id, ex);
        if (fz)                     exp_ctl = 7'b00000_00;
        else if (m_redir == 0 && mp) exp_ctl = 7'b11111_11;
        else if (m_redir == 0 && lu) exp_ctl = 7'b00111_01;
        else if (m_redir > 0)        exp_ctl = 7'b11111_10;
        else                         exp_ctl = 7'b11111_00;
        chk("ctl", 32'(ctl_obs()), 32'(exp_ctl));
        if (fz) begin
            m_wait = sat(m_wait + 1);
            m_run++;
            if (m_run >= MT) m_to = 1;
        end else begin
            m_run = 0;
            if (m_redir == 0) begin
                if (mp) begin
                    m_flush = sat(m_flush + 1);
                    m_redir = LAT - 1;
                end else if (lu) begin
                    m_stall = sat(m_stall + 1);
                end
            end else if (mp) begin
                m_redir = LAT - 1;
            end else begin
                m_redir--;
            end
        end
        @(posedge clk);
        #1;
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        chk("wait_cnt", 32'(wait_cnt), 32'(m_wait));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
        @(negedge clk);
    endtask

    localparam logic [31:0] I_NOP   = 32'h0000_0013;
    localparam logic [31:0] LW_X5   = 32'h0000_A283;
    localparam logic [31:0] ADD_X6  = 32'h0022_8333;
    localparam logic [31:0] LW_X0   = 32'h0000_A003;
    localparam logic [31:0] ADD_X0S = 32'h0020_0333;

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] id, ex;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h37, 7'h17, 7'h73};
        model_reset();
        bus.inst_id = I_NOP; bus.inst_ex = I_NOP;
        bus.mispredict_ex = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1;

        #3;
        chk("reset_ctl", 32'(ctl_obs()), 32'h0);
        chk("reset_stall", 32'(stall_cnt), 32'h0);
        chk("reset_wait", 32'(wait_cnt), 32'h0);
        chk("reset_to", 32'(mem_timeout), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        step(I_NOP, I_NOP, 0, 0, 1);

        // load-use with real destination: exactly one stall
        step(ADD_X6, LW_X5, 0, 0, 1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        step(I_NOP, I_NOP, 0, 0, 1);
        // load to x0 never stalls
        step(ADD_X0S, LW_X0, 0, 0, 1);
        chk("lu_x0_pc_en", 32'(bus.pc_en), 32'd1);

        // mispredict: two-cycle IF/ID flush
        step(I_NOP, I_NOP, 1, 0, 1);
        step(I_NOP, I_NOP, 0, 0, 1);
        step(I_NOP, I_NOP, 0, 0, 1);
        chk("mp_flush_cnt", 32'(flush_cnt), 32'd1);

        // freeze inside redirect window
        step(I_NOP, I_NOP, 1, 0, 1);
        repeat (3) step(I_NOP, I_NOP, 0, 1, 0);
        chk("fz_wait_cnt", 32'(wait_cnt), 32'd3);
        step(I_NOP, I_NOP, 0, 1, 1);
        step(I_NOP, I_NOP, 0, 0, 1);

        // mispredict beats load-use; freeze beats mispredict
        step(ADD_X6, LW_X5, 1, 0, 1);
        chk("mp_lu_stall", 32'(stall_cnt), 32'd1);
        step(I_NOP, I_NOP, 0, 0, 1);
        step(I_NOP, I_NOP, 1, 1, 0);
        step(I_NOP, I_NOP, 1, 0, 1);
        step(I_NOP, I_NOP, 0, 0, 1);

        // timeout boundary
        repeat (3) step(I_NOP, I_NOP, 0, 1, 0);
        chk("to_before", 32'(mem_timeout), 32'd0);
        step(I_NOP, I_NOP, 0, 1, 0);
        chk("to_at", 32'(mem_timeout), 32'd1);
        step(I_NOP, I_NOP, 0, 0, 1);
        chk("to_sticky", 32'(mem_timeout), 32'd1);

        // async reset between edges during a freeze
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ctl", 32'(ctl_obs()), 32'h0);
        chk("arst_wait", 32'(wait_cnt), 32'h0);
        chk("arst_flush", 32'(flush_cnt), 32'h0);
        chk("arst_to", 32'(mem_timeout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(I_NOP, I_NOP, 0, 0, 1);
        chk("arst_run_pc_en", 32'(bus.pc_en), 32'd1);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 1) == 1)
                ex = {12'($urandom), 5'($urandom_range(0, 3)), 3'b010, 5'($urandom_range(0, 3)), 7'h03};
            else
                ex = {25'($urandom), ops[$urandom_range(0, 9)]};
            id = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  3'($urandom), 5'($urandom), ops[$urandom_range(0, 9)]};
            step(id, ex, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
